// File: rtl/fmap_wr_arbiter.sv
// fmap_wr_arbiter: schedules the single feature-map BRAM write port (port A)
// between max-pool writeback (never stalls, always wins) and the host image
// loader (valid/ready). Applies the ping-pong bank base to pool writes and
// counts writes per phase, pulsing layer_done / load_done on completion.
// Optional build macro: FMAP_WR_ARB_STATS_EN adds the host_stall_cnt output.
module fmap_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 8,
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BANK_HI = 12'h400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  layer,
  input  logic                        layer_start,
  input  logic [ADDR_WIDTH-1:0]       wr_target,
  input  logic                        load_start,
  input  logic [ADDR_WIDTH-1:0]       load_words,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic [DATA_WIDTH*LANES-1:0] host_data,
  input  logic                        pool_valid,
  input  logic [ADDR_WIDTH-1:0]       pool_addr,
  input  logic [DATA_WIDTH*LANES-1:0] pool_data,
  output logic [ADDR_WIDTH-1:0]       bram_addra,
  output logic [DATA_WIDTH*LANES-1:0] bram_dina,
  output logic                        bram_wea,
  output logic                        busy,
  output logic                        layer_done,
  output logic                        load_done,
  output logic                        wr_err
`ifdef FMAP_WR_ARB_STATS_EN
  ,
  output logic [15:0]                 host_stall_cnt
`endif
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                state_r;
  logic [CW-1:0]         cnt_r;
  logic [3:0]            layer_r;
  logic [ADDR_WIDTH-1:0] target_r;
  logic [ADDR_WIDTH-1:0] words_r;

  logic [ADDR_WIDTH-1:0] bank_base_s;
  logic [ADDR_WIDTH-1:0] pool_wr_addr_s;
  logic [CW-1:0]         cnt_inc_s;
  logic                  host_fire_s;
  logic                  start_any_s;

  // Bank select from the latched layer, pool address offset, and count step.
  always_comb begin
    bank_base_s = {ADDR_WIDTH{1'b0}};
    if ((layer_r < 4'd4) || (layer_r > 4'd7)) begin
      bank_base_s = BANK_HI;
    end else begin
      bank_base_s = {ADDR_WIDTH{1'b0}};
    end
    pool_wr_addr_s = bank_base_s + pool_addr;
    // cnt is wide enough for any target; hold at all-ones rather than wrap
    if (cnt_r == {CW{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Pool always blocks the host; host is only ready while words remain.
  assign host_ready  = (state_r == ST_LOAD) && !pool_valid && (cnt_r < {1'b0, words_r});
  assign host_fire_s = host_ready && host_valid;
  assign start_any_s = layer_start || load_start;
  assign busy        = (state_r != ST_IDLE);

  // Phase FSM plus registered port-A write and done/error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      layer_r    <= 4'd0;
      target_r   <= {ADDR_WIDTH{1'b0}};
      words_r    <= {ADDR_WIDTH{1'b0}};
      bram_addra <= {ADDR_WIDTH{1'b0}};
      bram_dina  <= {(DATA_WIDTH*LANES){1'b0}};
      bram_wea   <= 1'b0;
      layer_done <= 1'b0;
      load_done  <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      bram_wea   <= 1'b0;
      layer_done <= 1'b0;
      load_done  <= 1'b0;
      // Port A: pool first, then an accepted host word
      if (pool_valid) begin
        bram_wea   <= 1'b1;
        bram_addra <= pool_wr_addr_s;
        bram_dina  <= pool_data;
        if (state_r != ST_RUN) begin
          wr_err <= 1'b1;
        end
      end else if (host_fire_s) begin
        bram_wea   <= 1'b1;
        bram_addra <= cnt_r[ADDR_WIDTH-1:0];
        bram_dina  <= host_data;
      end else begin
        bram_addra <= bram_addra;
        bram_dina  <= bram_dina;
      end
      case (state_r)
        ST_IDLE: begin
          if (load_start) begin
            state_r <= ST_LOAD;
            words_r <= load_words;
            cnt_r   <= {CW{1'b0}};
          end else if (layer_start) begin
            state_r  <= ST_RUN;
            layer_r  <= layer;
            target_r <= wr_target;
            cnt_r    <= {CW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (start_any_s) begin
            wr_err <= 1'b1;
          end
          if (words_r == {ADDR_WIDTH{1'b0}}) begin
            load_done <= 1'b1;
            state_r   <= ST_IDLE;
          end else if (host_fire_s) begin
            cnt_r <= cnt_inc_s;
            if (cnt_inc_s == {1'b0, words_r}) begin
              load_done <= 1'b1;
              state_r   <= ST_IDLE;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (start_any_s) begin
            wr_err <= 1'b1;
          end
          if (target_r == {ADDR_WIDTH{1'b0}}) begin
            layer_done <= 1'b1;
            state_r    <= ST_IDLE;
          end else if (pool_valid) begin
            cnt_r <= cnt_inc_s;
            if (cnt_inc_s == {1'b0, target_r}) begin
              layer_done <= 1'b1;
              state_r    <= ST_IDLE;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FMAP_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of LOAD cycles where the host offered data but was held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_IDLE) && load_start) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_LOAD) && host_valid && !host_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign host_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fmap_wr_arbiter.sv
// Self-checking bench for fmap_wr_arbiter: directed scenarios followed by
// randomized RUN/LOAD phases, scored against a transaction-level model.
module tb_fmap_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  layer = 4'd0;
  logic        layer_start = 1'b0;
  logic [11:0] wr_target = 12'd0;
  logic        load_start = 1'b0;
  logic [11:0] load_words = 12'd0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [63:0] host_data = 64'd0;
  logic        pool_valid = 1'b0;
  logic [11:0] pool_addr = 12'd0;
  logic [63:0] pool_data = 64'd0;
  logic [11:0] bram_addra;
  logic [63:0] bram_dina;
  logic        bram_wea;
  logic        busy;
  logic        layer_done;
  logic        load_done;
  logic        wr_err;
`ifdef FMAP_WR_ARB_STATS_EN
  logic [15:0] host_stall_cnt;
`endif

  fmap_wr_arbiter dut (
    .clk(clk), .rst(rst), .layer(layer), .layer_start(layer_start),
    .wr_target(wr_target), .load_start(load_start), .load_words(load_words),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .pool_valid(pool_valid), .pool_addr(pool_addr), .pool_data(pool_data),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
    .busy(busy), .layer_done(layer_done), .load_done(load_done), .wr_err(wr_err)
`ifdef FMAP_WR_ARB_STATS_EN
    , .host_stall_cnt(host_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which phase is open and how far along it is.
  bit       in_load = 1'b0;
  bit       in_run  = 1'b0;
  int       words_m = 0;
  int       acc_m   = 0;
  int       tgt_m   = 0;
  int       run_m   = 0;
  logic [3:0] lay_m = 4'd0;
  logic     exp_err = 1'b0;

  function automatic logic [11:0] base_of(input logic [3:0] l);
    return ((l < 4'd4) || (l > 4'd7)) ? 12'h400 : 12'h000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests; checks host_ready, then the port-A result.
  task automatic cyc(input bit pv, input logic [11:0] pa, input logic [63:0] pd,
                     input bit hv, input logic [63:0] hd);
    bit req, eld, elyd, zl, zr;
    logic exp_hr;
    logic [11:0] ea;
    logic [63:0] ed;
    pool_valid = pv; pool_addr = pa; pool_data = pd;
    host_valid = hv; host_data = hd;
    #1;
    exp_hr = in_load && !pv && (acc_m < words_m);
    chk("host_ready", {63'd0, host_ready}, {63'd0, exp_hr});
    req = 1'b0; eld = 1'b0; elyd = 1'b0; ea = 12'd0; ed = 64'd0;
    zl = in_load && (words_m == 0);
    zr = in_run && (tgt_m == 0);
    if (pv) begin
      req = 1'b1; ea = base_of(lay_m) + pa; ed = pd;
      if (!in_run) exp_err = 1'b1;
      else if (!zr) begin
        run_m++;
        if (run_m == tgt_m) begin elyd = 1'b1; in_run = 1'b0; end
      end
    end else if (exp_hr && hv) begin
      req = 1'b1; ea = acc_m[11:0]; ed = hd;
      acc_m++;
      if (acc_m == words_m) begin eld = 1'b1; in_load = 1'b0; end
    end
    if (zl) begin eld = 1'b1; in_load = 1'b0; end
    if (zr) begin elyd = 1'b1; in_run = 1'b0; end
    @(posedge clk); @(negedge clk);
    pool_valid = 1'b0; host_valid = 1'b0;
    chk("bram_wea", {63'd0, bram_wea}, {63'd0, req});
    if (req) begin
      chk("bram_addra", {52'd0, bram_addra}, {52'd0, ea});
      chk("bram_dina", bram_dina, ed);
    end
    chk("load_done", {63'd0, load_done}, {63'd0, eld});
    chk("layer_done", {63'd0, layer_done}, {63'd0, elyd});
    chk("busy", {63'd0, busy}, {63'd0, (in_load || in_run)});
    chk("wr_err", {63'd0, wr_err}, {63'd0, exp_err});
  endtask

  task automatic pulse_start(input bit ld, input bit ly, input int n, input logic [3:0] l, input int t);
    load_start = ld; load_words = n[11:0];
    layer_start = ly; layer = l; wr_target = t[11:0];
    @(posedge clk); @(negedge clk);
    load_start = 1'b0; layer_start = 1'b0;
    if (in_load || in_run) exp_err = 1'b1;
    else if (ld) begin in_load = 1'b1; words_m = n; acc_m = 0; end
    else if (ly) begin in_run = 1'b1; lay_m = l; tgt_m = t; run_m = 0; end
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("err_after_start", {63'd0, wr_err}, {63'd0, exp_err});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wea"}, {63'd0, bram_wea}, 64'd0);
    chk({tag, "_addra"}, {52'd0, bram_addra}, 64'd0);
    chk({tag, "_dina"}, bram_dina, 64'd0);
    chk({tag, "_host_ready"}, {63'd0, host_ready}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_layer_done"}, {63'd0, layer_done}, 64'd0);
    chk({tag, "_load_done"}, {63'd0, load_done}, 64'd0);
    chk({tag, "_wr_err"}, {63'd0, wr_err}, 64'd0);
  endtask

  initial begin
    int k;
    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // LOAD 4 words, host always valid
    pulse_start(1'b1, 1'b0, 4, 4'd0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 12'd0, 64'd0, 1'b1, {32'hA5A5_0000, i});
    chk("load4_addr_last", {52'd0, bram_addra}, 64'h3);

    // RUN layer 2 (high bank) then layer 5 (low bank)
    pulse_start(1'b0, 1'b1, 0, 4'd2, 3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'h010 + i[11:0], {32'hBEEF_0000, i}, 1'b0, 64'd0);
    chk("run_l2_addr_last", {52'd0, bram_addra}, 64'h412);
    pulse_start(1'b0, 1'b1, 0, 4'd5, 3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'h010 + i[11:0], {32'hCAFE_0000, i}, 1'b0, 64'd0);
    chk("run_l5_addr_last", {52'd0, bram_addra}, 64'h012);

    // Zero target (layer 6 -> low bank stays latched)
    pulse_start(1'b0, 1'b1, 0, 4'd6, 0);
    cyc(1'b0, 12'd0, 64'd0, 1'b0, 64'd0);

    // Simultaneous starts: LOAD wins; later layer_start while busy is an error
    pulse_start(1'b1, 1'b1, 1, 4'd3, 2);
    pulse_start(1'b0, 1'b1, 0, 4'd3, 2);
    cyc(1'b0, 12'd0, 64'd0, 1'b1, 64'h1234_5678_9ABC_DEF0);
    // Pool in IDLE still uses layer 6 (dropped layer 3 never latched)
    cyc(1'b1, 12'h033, 64'h0000_0000_0000_0033, 1'b0, 64'd0);
    chk("idle_pool_addr", {52'd0, bram_addra}, 64'h033);

    // Reset mid-RUN after 2 of 5 pool writes
    pulse_start(1'b0, 1'b1, 0, 4'd9, 5);
    cyc(1'b1, 12'h001, 64'h11, 1'b0, 64'd0);
    cyc(1'b1, 12'h002, 64'h22, 1'b0, 64'd0);
    pool_valid = 1'b1; pool_addr = 12'h003; pool_data = 64'h33;
    @(posedge clk); #2;
    chk("pending_wea", {63'd0, bram_wea}, 64'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    pool_valid = 1'b0; rst = 1'b0;
    in_load = 1'b0; in_run = 1'b0; lay_m = 4'd0; exp_err = 1'b0;
    cyc(1'b0, 12'd0, 64'd0, 1'b0, 64'd0);
    cyc(1'b0, 12'd0, 64'd0, 1'b0, 64'd0);

    // Collision in LOAD: pool wins, host held one cycle
    pulse_start(1'b1, 1'b0, 2, 4'd0, 0);
    cyc(1'b1, 12'h020, 64'hFEED, 1'b1, 64'hAAAA);
    chk("collision_addr", {52'd0, bram_addra}, 64'h420);
`ifdef FMAP_WR_ARB_STATS_EN
    chk("host_stall_cnt", {48'd0, host_stall_cnt}, 64'd1);
`endif
    cyc(1'b0, 12'd0, 64'd0, 1'b1, 64'hAAAA);
    cyc(1'b0, 12'd0, 64'd0, 1'b1, 64'hBBBB);

    // Randomized RUN and LOAD phases
    for (int r = 0; r < 8; r++) begin
      pulse_start(1'b0, 1'b1, 0, 4'($urandom_range(0, 15)), int'($urandom_range(1, 8)));
      k = 0;
      while (in_run && k < 200) begin
        cyc(1'($urandom_range(0, 1)), 12'($urandom), {$urandom, $urandom}, 1'b0, 64'd0);
        k++;
      end
      chk("run_bound", {63'd0, in_run}, 64'd0);
      pulse_start(1'b1, 1'b0, int'($urandom_range(0, 6)), 4'd0, 0);
      k = 0;
      while (in_load && k < 200) begin
        cyc(($urandom_range(0, 3) == 0), 12'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 1)), {$urandom, $urandom});
        k++;
      end
      chk("load_bound", {63'd0, in_load}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
